// File: rtl/usb_ls_tx_wb.sv
// Wishbone-controlled USB low-speed transmitter: SYNC, PID, payload + CRC16, NRZI, bit stuffing, EOP.
// Token packets (PID[1:0]=01, 11 bits + CRC5) are compiled in when USB_TX_TOKEN_EN is defined.
module usb_ls_tx_wb #(
   parameter int unsigned CLK_DIV = 32
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   input  logic        wb_cyc_i,
   output logic        usb_dp_o,
   output logic        usb_dm_o,
   output logic        usb_oe_o,
   output logic        int_o
);

   localparam int unsigned TW = $clog2(CLK_DIV);

   typedef enum logic [2:0] {
      StIdle, StSync, StPid, StData, StCrc, StToken, StEopSe0, StEopJ
   } state_e;

   logic [3:0]    pid;
   logic [3:0]    len;
   logic          ie, busy, done, err, go;
   logic [31:0]   data0, data1;
   logic [31:0]   rd_data;
   logic          bus_req, ctrl_wr, data_wr, tok_rej, start_ok, pkt_end;
   logic          unused_adr;

   state_e        state, nxt_state;
   logic [TW-1:0] tick;
   logic [5:0]    idx;
   logic [2:0]    ones;
   logic          lvl;  // current line level, 1 = J
   logic [15:0]   crc16, crc16_upd;
   logic [63:0]   payload;
   logic [7:0]    pid_byte;
   logic [6:0]    data_bits;
   logic          last_tick, cur_bit, field_last, stuff_now, nxt_lvl;
`ifdef USB_TX_TOKEN_EN
   logic [4:0]    crc5, crc5_upd;
`endif

   assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};
   assign bus_req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign ctrl_wr    = bus_req & wb_we_i & (wb_adr_i[3:2] == 2'd0);
   assign data_wr    = bus_req & wb_we_i & ((wb_adr_i[3:2] == 2'd1) | (wb_adr_i[3:2] == 2'd2));
`ifdef USB_TX_TOKEN_EN
   assign tok_rej    = 1'b0;
`else
   assign tok_rej    = (wb_dat_i[1:0] == 2'b01);
`endif
   assign start_ok   = ctrl_wr & wb_dat_i[31] & ~busy & ~tok_rej;
   assign int_o      = done & ie;

   always_comb begin
      rd_data = '0;
      case (wb_adr_i[3:2])
         2'd0:    rd_data = {15'b0, ie, 4'b0, len, pid, 1'b0, err, done, busy};
         2'd1:    rd_data = data0;
         2'd2:    rd_data = data1;
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= '0;
         pid      <= '0;
         len      <= '0;
         ie       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         go       <= 1'b0;
         data0    <= '0;
         data1    <= '0;
      end else begin
         wb_ack_o <= bus_req;
         go       <= start_ok;
         if (bus_req) wb_dat_o <= rd_data;
         if (ctrl_wr) begin
            ie <= wb_dat_i[16];
            if (wb_dat_i[1]) done <= 1'b0;
            if (wb_dat_i[2]) err <= 1'b0;
            if (!busy) begin
               pid <= wb_dat_i[3:0];
               len <= (wb_dat_i[11:8] > 4'd8) ? 4'd8 : wb_dat_i[11:8];
            end
            if (wb_dat_i[31] && (busy || tok_rej)) err <= 1'b1;
            if (start_ok) busy <= 1'b1;
         end
         if (data_wr) begin
            if (busy) begin
               err <= 1'b1;
            end else begin
               for (int b = 0; b < 4; b++) begin
                  if (wb_sel_i[b]) begin
                     if (wb_adr_i[2]) data0[8*b +: 8] <= wb_dat_i[8*b +: 8];
                     else             data1[8*b +: 8] <= wb_dat_i[8*b +: 8];
                  end
               end
            end
         end
         if (pkt_end) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

   assign payload   = {data1, data0};
   assign pid_byte  = {~pid, pid};
   assign data_bits = {len, 3'b000};
   assign last_tick = (tick == TW'(CLK_DIV - 1));
   assign pkt_end   = (state == StEopJ) && (idx == 6'd1) && last_tick;
   assign crc16_upd = {1'b0, crc16[15:1]} ^ ((crc16[0] ^ cur_bit) ? 16'hA001 : 16'h0000);
`ifdef USB_TX_TOKEN_EN
   assign crc5_upd  = {1'b0, crc5[4:1]} ^ ((crc5[0] ^ cur_bit) ? 5'h14 : 5'h00);
`endif

   // Selects the next unstuffed bit of the current field and where the packet goes after it.
   always_comb begin
      cur_bit    = 1'b0;
      field_last = 1'b0;
      nxt_state  = state;
      case (state)
         StSync: begin
            cur_bit    = (idx == 6'd7);
            field_last = (idx == 6'd7);
            nxt_state  = StPid;
         end
         StPid: begin
            cur_bit    = pid_byte[idx[2:0]];
            field_last = (idx == 6'd7);
            if (pid[1:0] == 2'b11)      nxt_state = (len == 4'd0) ? StCrc : StData;
`ifdef USB_TX_TOKEN_EN
            else if (pid[1:0] == 2'b01) nxt_state = StToken;
`endif
            else                        nxt_state = StEopSe0;
         end
         StData: begin
            cur_bit    = payload[idx];
            field_last = ({1'b0, idx} == data_bits - 7'd1);
            nxt_state  = StCrc;
         end
         StCrc: begin
            cur_bit    = ~crc16[0];
            field_last = (idx == 6'd15);
            nxt_state  = StEopSe0;
         end
`ifdef USB_TX_TOKEN_EN
         StToken: begin
            cur_bit    = (idx < 6'd11) ? payload[idx] : ~crc5[0];
            field_last = (idx == 6'd15);
            nxt_state  = StEopSe0;
         end
`endif
         default: ;
      endcase
      // EopSe0 is included so a stuff bit owed after the last CRC bit goes out before SE0.
      stuff_now = (ones == 3'd6) && (state == StPid || state == StData || state == StCrc ||
                                     state == StToken || state == StEopSe0);
      nxt_lvl   = (stuff_now || !cur_bit) ? ~lvl : lvl;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= StIdle;
         tick     <= '0;
         idx      <= '0;
         ones     <= '0;
         lvl      <= 1'b1;
         crc16    <= '1;
`ifdef USB_TX_TOKEN_EN
         crc5     <= '1;
`endif
         usb_oe_o <= 1'b0;
         usb_dp_o <= 1'b0;
         usb_dm_o <= 1'b1;
      end else if (state == StIdle) begin
         if (go) begin
            // First SYNC bit is a 0, so the line leaves idle J for K.
            state    <= StSync;
            idx      <= 6'd1;
            tick     <= '0;
            ones     <= '0;
            crc16    <= '1;
`ifdef USB_TX_TOKEN_EN
            crc5     <= '1;
`endif
            lvl      <= 1'b0;
            usb_oe_o <= 1'b1;
            usb_dp_o <= 1'b1;
            usb_dm_o <= 1'b0;
         end
      end else if (!last_tick) begin
         tick <= tick + 1'b1;
      end else begin
         tick <= '0;
         if (state == StEopJ) begin
            if (idx == 6'd0) begin
               usb_dp_o <= 1'b0;
               usb_dm_o <= 1'b1;
               idx      <= 6'd1;
            end else begin
               state    <= StIdle;
               usb_oe_o <= 1'b0;
               lvl      <= 1'b1;
               idx      <= '0;
            end
         end else if (state == StEopSe0 && !stuff_now) begin
            usb_dp_o <= 1'b0;
            usb_dm_o <= 1'b0;
            ones     <= '0;
            if (idx == 6'd1) begin
               state <= StEopJ;
               idx   <= '0;
            end else begin
               idx <= idx + 6'd1;
            end
         end else begin
            lvl      <= nxt_lvl;
            usb_dp_o <= ~nxt_lvl;
            usb_dm_o <= nxt_lvl;
            if (stuff_now) begin
               ones <= '0;
            end else begin
               if (state != StSync) ones <= cur_bit ? ones + 3'd1 : 3'd0;
               if (state == StData) crc16 <= crc16_upd;
               if (state == StCrc)  crc16 <= crc16 >> 1;
`ifdef USB_TX_TOKEN_EN
               if (state == StToken) crc5 <= (idx < 6'd11) ? crc5_upd : (crc5 >> 1);
`endif
               if (field_last) begin
                  state <= nxt_state;
                  idx   <= '0;
               end else begin
                  idx <= idx + 6'd1;
               end
            end
         end
      end
   end

endmodule
